// File: rtl/qspi_rom_responder.sv
// qspi_rom_responder: device side of a quad-SPI cartridge-ROM link. Emulates a
// serial flash answering fast-read-quad (0xEB) from an attached byte-wide memory.
// SCK/CS/IO are oversampled by clk. Optional feature macro:
//   QSPI_ROM_RESPONDER_CONTINUOUS_READ_EN - honour the continuous-read mode byte
//   so the following transaction starts with the address (no command byte).
module qspi_rom_responder #(
  parameter int ADDR_BITS   = 24,
  parameter int SYNC_STAGES = 2,
  parameter int DUMMY_CLKS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_select,
  input  logic                 spi_clk,
  input  logic [3:0]           spi_data_in,
  output logic [3:0]           spi_data_out,
  output logic [3:0]           spi_data_oe,
  output logic                 mem_rd,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [7:0]           mem_data,
  output logic                 active,
  output logic                 cmd_error
);

  localparam int                   ADDR_NIBBLES = ADDR_BITS / 4;
  localparam logic [7:0]           CMD_QUAD_READ = 8'hEB;
  localparam logic [7:0]           CMD_LAST      = 8'd7;
  localparam logic [7:0]           ADDR_LAST     = 8'(ADDR_NIBBLES - 1);
  localparam logic [7:0]           MODE_LAST     = 8'd1;
  localparam logic [7:0]           DUMMY_LAST    = 8'(DUMMY_CLKS);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE      = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_IGNORE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SYNC_STAGES-1:0]      r_cs_sync;
  logic [SYNC_STAGES-1:0]      r_sck_sync;
  logic [SYNC_STAGES-1:0][3:0] r_io_sync;
  logic                        r_cs_prev;
  logic                        r_sck_prev;

  logic       w_cs_n;
  logic       w_sck;
  logic [3:0] w_io;
  logic       w_cs_fall;
  logic       w_rise;
  logic       w_fall;
  logic       w_start_addr;
  logic [7:0] w_cmd_byte;

  logic [7:0]           r_cnt;
  logic [6:0]           r_cmd;
  logic [ADDR_BITS-1:0] r_addr;
  logic [ADDR_BITS-1:0] r_mem_addr;
  logic [7:0]           r_shift;
  logic [3:0]           r_low;
  logic [3:0]           r_data_out;
  logic [3:0]           r_data_oe;
  logic                 r_hi_next;
  logic                 r_mem_rd;
  logic                 r_rd_pending;
  logic                 r_cmd_error;

  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_io       = r_io_sync[SYNC_STAGES-1];
  assign w_cs_fall  = r_cs_prev & ~w_cs_n;
  assign w_rise     = w_sck & ~r_sck_prev;
  assign w_fall     = ~w_sck & r_sck_prev;
  assign w_cmd_byte = {r_cmd, w_io[0]};

`ifdef QSPI_ROM_RESPONDER_CONTINUOUS_READ_EN
  logic [1:0] r_mode_bits;
  logic       r_cont;
  assign w_start_addr = r_cont;
`else
  assign w_start_addr = 1'b0;
`endif

  // Synchronize bus inputs and remember the previous samples for edge detection.
  always_ff @(posedge clk) begin
    // NOTE: synchronizers reset to the idle bus level (CS high, SCK low) so no
    // phantom CS fall or SCK edge is seen as reset releases.
    if (reset) begin
      r_cs_sync  <= '1;
      r_sck_sync <= '0;
      r_io_sync  <= '0;
      r_cs_prev  <= 1'b1;
      r_sck_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop in the chain samples pre-edge values.
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], spi_select};
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_clk};
      r_io_sync  <= {r_io_sync[SYNC_STAGES-2:0], spi_data_in};
      r_cs_prev  <= w_cs_n;
      r_sck_prev <= w_sck;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; a deasserted CS overrides any SCK edge in the same clk.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    if (w_cs_n) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_cs_fall) w_next = w_start_addr ? S_ADDR : S_CMD;
        S_CMD:   if (w_rise && r_cnt == CMD_LAST)
                   w_next = (w_cmd_byte == CMD_QUAD_READ) ? S_ADDR : S_IGNORE;
        S_ADDR:  if (w_rise && r_cnt == ADDR_LAST) w_next = S_MODE;
        S_MODE:  if (w_rise && r_cnt == MODE_LAST) w_next = S_DUMMY;
        S_DUMMY: if (w_fall && r_cnt == DUMMY_LAST) w_next = S_DATA;
        default: ;
      endcase
    end
  end

  // Datapath: sample on SCK rise, drive on SCK fall, prefetch one byte ahead.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_cmd        <= '0;
      r_addr       <= '0;
      r_mem_addr   <= '0;
      r_shift      <= '0;
      r_low        <= '0;
      r_data_out   <= '0;
      r_data_oe    <= '0;
      r_hi_next    <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_rd_pending <= 1'b0;
      r_cmd_error  <= 1'b0;
`ifdef QSPI_ROM_RESPONDER_CONTINUOUS_READ_EN
      r_mode_bits  <= '0;
      r_cont       <= 1'b0;
`endif
    end else begin
      r_mem_rd     <= 1'b0;
      r_rd_pending <= r_mem_rd;
      // Memory answers one clk after the strobe.
      if (r_rd_pending) r_shift <= mem_data;

      if (w_next != r_state) r_cnt <= '0;
      else if (w_rise)       r_cnt <= r_cnt + 8'd1;

      if (w_cs_n) begin
        r_data_oe  <= '0;
        r_data_out <= '0;
      end else begin
        case (r_state)
          S_CMD: if (w_rise) begin
            r_cmd <= w_cmd_byte[6:0];
            if (r_cnt == CMD_LAST && w_cmd_byte != CMD_QUAD_READ) r_cmd_error <= 1'b1;
          end
          S_ADDR: if (w_rise) r_addr <= {r_addr[ADDR_BITS-5:0], w_io};
          S_MODE: if (w_rise) begin
`ifdef QSPI_ROM_RESPONDER_CONTINUOUS_READ_EN
            // Mode byte bits [5:4] arrive as bits [1:0] of the first nibble.
            if (r_cnt == 8'd0) r_mode_bits <= w_io[1:0];
            else               r_cont      <= (r_mode_bits == 2'b10);
`endif
            if (r_cnt == MODE_LAST) begin
              r_mem_rd   <= 1'b1;
              r_mem_addr <= r_addr;
              r_addr     <= r_addr + ADDR_ONE;
            end
          end
          S_DUMMY: if (w_fall && r_cnt == DUMMY_LAST) begin
            r_data_oe  <= 4'hF;
            r_data_out <= r_shift[7:4];
            r_low      <= r_shift[3:0];
            r_hi_next  <= 1'b0;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= r_addr;
            r_addr     <= r_addr + ADDR_ONE;
          end
          S_DATA: if (w_fall) begin
            if (r_hi_next) begin
              // Low nibble is parked so the shift register can take the next byte.
              r_data_out <= r_shift[7:4];
              r_low      <= r_shift[3:0];
              r_hi_next  <= 1'b0;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= r_addr;
              r_addr     <= r_addr + ADDR_ONE;
            end else begin
              r_data_out <= r_low;
              r_hi_next  <= 1'b1;
            end
          end
          S_IGNORE: r_data_oe <= '0;
          default: ;
        endcase
      end
    end
  end

  assign spi_data_out = r_data_out;
  assign spi_data_oe  = r_data_oe;
  assign mem_rd       = r_mem_rd;
  assign mem_addr     = r_mem_addr;
  assign active       = ~w_cs_n;
  assign cmd_error    = r_cmd_error;

endmodule

// File: doc/qspi_rom_responder.md
Name: qspi_rom_responder

Overview:
- Device side of the quad-SPI cartridge-ROM link: behaves as the serial flash that the console's QSPI flash controller reads from.
- Receives CS/SCK/IO from the bus and serves bytes from an attached byte-wide memory.
- SCK is oversampled by `clk`; the block is used for on-chip loopback testing of the flash controller and for bench emulation of the flash PMOD.

Parameters:
- ADDR_BITS, 24, width of the flash address sent on the bus and of `mem_addr`.
- SYNC_STAGES, 2, synchronizer flops on spi_select, spi_clk and spi_data_in (minimum 2).
- DUMMY_CLKS, 4, SCK cycles between the mode byte and the first data nibble.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- spi_select  input  1  chip select, active low.
- spi_clk  input  1  SCK from the initiator, idles low (mode 0); high and low phases each ≥3 clk.
- spi_data_in  input  4  IO3..IO0 from the bus.
- spi_data_out  output  4  IO3..IO0 driven to the bus.
- spi_data_oe  output  4  per-bit output enable, active high.
- mem_rd  output  1  one-cycle memory read strobe.
- mem_addr  output  ADDR_BITS  memory read address, valid while mem_rd is high.
- mem_data  input  8  read data, valid exactly 1 clk after mem_rd.
- active  output  1  high from CS fall until CS rise (synchronized).
- cmd_error  output  1  sticky flag: unsupported command received; cleared by reset only.

Behaviour:
- Reset values: spi_data_out=0, spi_data_oe=0, mem_rd=0, mem_addr=0, active=0, cmd_error=0; FSM=IDLE.
- Edge detection:
  - Every input passes through SYNC_STAGES flops.
  - SCK rise = sync high and previous sync low; SCK fall = the reverse.
  - Inputs are sampled on a detected rise; outputs are updated on a detected fall.
- FSM states: IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE.
- CS handling: CS high (synchronized) forces IDLE from any state within 1 clk and sets spi_data_oe=0. A CS fall moves IDLE→CMD with the bit counter at 0.
- CMD:
  - 8 rises sample IO0 MSB-first.
  - Byte 0xEB → ADDR.
  - Any other byte → IGNORE and cmd_error<=1.
- ADDR: ADDR_BITS/4 rises sample the quad nibble, MSB nibble first.
- MODE:
  - 2 rises sample the mode byte.
  - On the 2nd rise: mem_rd=1 and mem_addr=address; the returned byte goes to the shift register.
  - The address increments mod 2^ADDR_BITS.
  - Then → DUMMY.
- DUMMY:
  - Counts DUMMY_CLKS rises with outputs tristated.
  - On the fall following the last dummy rise: oe=4'hF and out=byte[7:4].
  - Then → DATA.
- DATA:
  - On each fall, drive the next nibble, high nibble then low nibble, continuously.
  - When the high nibble of byte N is placed on the bus, issue mem_rd for byte N+1.
  - Byte N+1 is loaded into the shift register before byte N's low-nibble fall completes.
  - The address wraps from 2^ADDR_BITS-1 to 0.
- IGNORE: oe=0 until CS rises.
- Mid-transaction CS rise: the transaction is aborted; no partial state is kept except under the optional feature.
- Simultaneous CS rise and SCK edge in the same clk: CS wins and the edge is discarded.
- mem_rd is never asserted in IDLE, CMD, ADDR or IGNORE.
- active = !spi_select_sync.

Optional Feature:
- Macro: QSPI_ROM_RESPONDER_CONTINUOUS_READ_EN.
- When defined:
  - A mode byte with bits [5:4]==2'b10 (e.g. 0xA0) sets a continuous flag, latched at the end of MODE.
  - The next CS fall enters ADDR directly, skipping CMD.
  - A mode byte with any other value clears the flag.
  - Reset clears the flag.
- When undefined: the mode byte is sampled and ignored, and every transaction starts in CMD.

Test Plan:
- Basic read:
  - Memory preloaded with mem[0x001000+i]=i+0x10.
  - CS low, cmd 0xEB, addr 0x001000, mode 0xFF, 4 dummies, 8 data SCKs.
  - Bus nibbles 1,0,1,1,1,2,1,3; mem_rd addresses 0x001000..0x001004 in order.
- Address wrap (ADDR_BITS=24):
  - Addr 0xFFFFFF, mem[0xFFFFFF]=0xAB, mem[0]=0xCD.
  - Read 2 bytes → nibbles A,B,C,D.
- Bad command:
  - Cmd 0x03 → cmd_error=1; oe stays 0 for all following SCKs; after CS high, an 0xEB read works normally and cmd_error stays 1.
- Abort:
  - CS rises after 3 address nibbles → oe=0 within SYNC_STAGES+1 clk and no mem_rd.
  - A new full read from 0x000020 returns mem[0x20].
- Continuous read (macro defined):
  - Read with mode 0xA0, CS high, then CS low with address-first transaction at 0x000040 → returns mem[0x40].
  - Mode 0xFF then clears the flag, so the next transaction needs 0xEB.
- Reset mid-DATA:
  - Assert reset during data → all outputs 0, FSM IDLE on the next clk; the next full read is correct.
